// File: rtl/video_framer_pkg.sv
// video_framer_pkg
// Shared definitions for the raster stream transmitter: the pixel width,
// the framer FSM state encoding, and a helper that sizes counters.
package video_framer_pkg;

  localparam int PIXEL_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    FRAME,
    LINE,
    ACTIVE,
    HBLK,
    VBLK
  } framerState_e;

  // Bits needed to hold 0..maxVal; never less than one so that a zero-length
  // blanking parameter still yields a legal vector.
  function automatic int cntWidth(input int maxVal);
    return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/video_framer_pixel_fifo.sv
// pixel_fifo
// Synchronous first-word-fall-through FIFO for raw pixels.
// Ports:
//   Clk, Reset        clock, synchronous active-high reset
//   push, pushData    write request and data (ignored while full)
//   pop               read request (ignored while empty)
//   popData           current head entry, valid while !empty
//   full, empty       occupancy flags
// A word written in cycle n becomes visible at the head in cycle n+1; there
// is no same-cycle bypass from pushData to popData.
module pixel_fifo
  import video_framer_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               push,
  input  logic [PIXEL_W-1:0] pushData,
  input  logic               pop,
  output logic [PIXEL_W-1:0] popData,
  output logic               full,
  output logic               empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PIXEL_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wrPtr;
  logic [PTR_W-1:0]   rdPtr;
  logic [CNT_W-1:0]   count;
  logic               doPush;
  logic               doPop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign doPush  = push && !full;
  assign doPop   = pop && !empty;
  assign popData = mem[rdPtr];

  // NOTE: the storage array is deliberately left out of reset; only the
  // pointers and count define what is valid, so clearing every entry would
  // just add reset fan-out for no behavioural gain.
  always_ff @(posedge Clk) begin
    if (doPush) begin
      mem[wrPtr] <= pushData;
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/video_framer.sv
// video_framer
// Raster stream transmitter: buffers raw pixels from a valid/ready input and
// replays them as a Pixel/Frame/Line stream with horizontal and vertical
// blanking. Raster timing is free-running once a frame starts; an empty FIFO
// during an active slot emits 0 and latches Underrun.
// Ports:
//   Clk, Reset   clock, synchronous active-high reset
//   Enable       permits a new frame to start (looked at only in IDLE)
//   InData       pixel to buffer
//   InValid      InData valid
//   InReady      buffer can accept (transfer on InValid && InReady)
//   PixelOut     raster pixel, 0 outside the active region
//   FrameOut     one-cycle frame-start strobe
//   LineOut      one-cycle line-start strobe
//   Busy         frame in progress
//   Underrun     sticky: an active slot found the buffer empty
// All raster outputs are registered from the current state, so they trail
// the FSM by one cycle.
module video_framer
  import video_framer_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int HEIGHT     = 48,
  parameter int HBLANK     = 4,
  parameter int VBLANK     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Enable,
  input  logic [PIXEL_W-1:0] InData,
  input  logic               InValid,
  output logic               InReady,
  output logic [PIXEL_W-1:0] PixelOut,
  output logic               FrameOut,
  output logic               LineOut,
  output logic               Busy,
  output logic               Underrun
);

  localparam int BLANK_MAX = (HBLANK > VBLANK) ? HBLANK : VBLANK;
  localparam int PIX_W     = cntWidth(WIDTH);
  localparam int LINE_W    = cntWidth(HEIGHT);
  localparam int BLANK_W   = cntWidth(BLANK_MAX);

  framerState_e       state;
  logic [PIX_W-1:0]   pixCnt;
  logic [LINE_W-1:0]  lineCnt;
  logic [BLANK_W-1:0] blankCnt;

  logic [PIXEL_W-1:0] fifoData;
  logic               fifoFull;
  logic               fifoEmpty;
  logic               activeSlot;

  assign activeSlot = (state == ACTIVE);
  assign InReady    = !fifoFull;

  pixel_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .Clk     (Clk),
    .Reset   (Reset),
    .push    (InValid),
    .pushData(InData),
    .pop     (activeSlot),
    .popData (fifoData),
    .full    (fifoFull),
    .empty   (fifoEmpty)
  );

  // Where to go once a line (including its horizontal blanking) is done.
  // linesDone is the count before this line is added.
  function automatic framerState_e nextAfterLine(input logic [LINE_W-1:0] linesDone);
    framerState_e nxt;
    nxt = LINE;
    if (int'(linesDone) + 1 == HEIGHT) begin
      if (VBLANK > 0) nxt = VBLK;
      else            nxt = IDLE;
    end
    return nxt;
  endfunction

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      pixCnt   <= '0;
      lineCnt  <= '0;
      blankCnt <= '0;
      PixelOut <= '0;
      FrameOut <= 1'b0;
      LineOut  <= 1'b0;
      Busy     <= 1'b0;
      Underrun <= 1'b0;
    end else begin
      FrameOut <= (state == FRAME);
      LineOut  <= (state == LINE);
      Busy     <= (state != IDLE);
      PixelOut <= (activeSlot && !fifoEmpty) ? fifoData : '0;
      // Timing never stalls on a starved slot; the gap is only flagged.
      if (activeSlot && fifoEmpty) Underrun <= 1'b1;

      case (state)
        IDLE: begin
          if (Enable && !fifoEmpty) state <= FRAME;
        end

        FRAME: begin
          lineCnt <= '0;
          state   <= LINE;
        end

        LINE: begin
          pixCnt <= '0;
          state  <= ACTIVE;
        end

        ACTIVE: begin
          pixCnt <= pixCnt + 1'b1;
          if (int'(pixCnt) == WIDTH - 1) begin
            blankCnt <= '0;
            if (HBLANK > 0) begin
              state <= HBLK;
            end else begin
              lineCnt <= lineCnt + 1'b1;
              state   <= nextAfterLine(lineCnt);
            end
          end
        end

        HBLK: begin
          if (int'(blankCnt) == HBLANK - 1) begin
            blankCnt <= '0;
            lineCnt  <= lineCnt + 1'b1;
            state    <= nextAfterLine(lineCnt);
          end else begin
            blankCnt <= blankCnt + 1'b1;
          end
        end

        VBLK: begin
          if (int'(blankCnt) == VBLANK - 1) state <= IDLE;
          else                              blankCnt <= blankCnt + 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_video_framer.sv
// tb_video_framer
// Drives two framer instances (a blanked 4x2 raster and a zero-blanking 4x2
// raster) through a shared stimulus path selected by `sel`. Expected outputs
// come from a raster-slot model (which cycle after FrameOut carries a strobe
// or a pixel) plus a queue of accepted pixels.
module tb_video_framer;

  localparam int W     = 4;
  localparam int H     = 2;
  localparam int HB    = 2;
  localparam int VB    = 3;
  localparam int DEPTH = 16;

  localparam int KIND_NONE  = 0;
  localparam int KIND_FRAME = 1;
  localparam int KIND_LINE  = 2;
  localparam int KIND_PIXEL = 3;

  logic       Clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       inValid;
  logic [7:0] inData;
  logic       sel;

  logic       ready1, frame1, line1, busy1, under1;
  logic [7:0] pix1;
  logic       ready2, frame2, line2, busy2, under2;
  logic [7:0] pix2;

  logic       obsReady, obsFrame, obsLine, obsBusy, obsUnder;
  logic [7:0] obsPix;

  int         errors = 0;
  int         checks = 0;
  int         cyc    = 0;
  logic [7:0] model[$];
  logic       expUnder;
  int         cW, cH, cHB, cVB;

  always #5 Clk = ~Clk;

  video_framer #(
    .WIDTH(W), .HEIGHT(H), .HBLANK(HB), .VBLANK(VB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .Clk(Clk), .Reset(reset), .Enable(enable & ~sel), .InData(inData),
    .InValid(inValid & ~sel), .InReady(ready1), .PixelOut(pix1),
    .FrameOut(frame1), .LineOut(line1), .Busy(busy1), .Underrun(under1)
  );

  video_framer #(
    .WIDTH(W), .HEIGHT(H), .HBLANK(0), .VBLANK(0), .FIFO_DEPTH(DEPTH)
  ) dutNoBlank (
    .Clk(Clk), .Reset(reset), .Enable(enable & sel), .InData(inData),
    .InValid(inValid & sel), .InReady(ready2), .PixelOut(pix2),
    .FrameOut(frame2), .LineOut(line2), .Busy(busy2), .Underrun(under2)
  );

  assign obsReady = sel ? ready2 : ready1;
  assign obsFrame = sel ? frame2 : frame1;
  assign obsLine  = sel ? line2  : line1;
  assign obsBusy  = sel ? busy2  : busy1;
  assign obsUnder = sel ? under2 : under1;
  assign obsPix   = sel ? pix2   : pix1;

  // ---------------- reference raster model ----------------
  function automatic int frameLen();
    return 1 + cH * (1 + cW + cHB) + cVB;
  endfunction

  // What the output stream carries k cycles after the FrameOut strobe.
  function automatic int slotKind(input int k);
    int j, lineLen, pos;
    if (k == 0) return KIND_FRAME;
    j       = k - 1;
    lineLen = 1 + cW + cHB;
    if (j >= cH * lineLen) return KIND_NONE;
    pos = j % lineLen;
    if (pos == 0) return KIND_LINE;
    if (pos <= cW) return KIND_PIXEL;
    return KIND_NONE;
  endfunction

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic selectDut(input logic s);
    sel = s;
    cW  = W;
    cH  = H;
    cHB = s ? 0 : HB;
    cVB = s ? 0 : VB;
  endtask

  task automatic doReset();
    reset   = 1'b1;
    enable  = 1'b0;
    inValid = 1'b0;
    inData  = '0;
    step();
    step();
    reset    = 1'b0;
    expUnder = 1'b0;
    model.delete();
  endtask

  // Push n pixels (1..n when seq, random otherwise), checking InReady.
  task automatic pushPixels(input int n, input bit seq);
    logic [7:0] v;
    bit         expReady;
    for (int i = 0; i < n; i++) begin
      v        = seq ? 8'(i + 1) : 8'($urandom);
      expReady = (model.size() < DEPTH);
      inValid  = 1'b1;
      inData   = v;
      checks++;
      if (obsReady !== expReady) begin
        errors++;
        $display("FAIL in_ready push %0d: got %b want %b", i, obsReady, expReady);
      end
      step();
      if (expReady) model.push_back(v);
    end
    inValid = 1'b0;
  endtask

  task automatic waitFrame(input string name, output bit found);
    found = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (obsFrame === 1'b1) begin
        found = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s frame_start: got no FrameOut within 80 cycles, want one", name);
    end
  endtask

  // Wait for a frame and check every output cycle of it against the model.
  task automatic runFrame(input string name);
    bit         found;
    int         fl, kind;
    logic [7:0] expPix;
    waitFrame(name, found);
    if (!found) return;
    enable = 1'b0;
    fl     = frameLen();
    for (int k = 0; k <= fl; k++) begin
      kind   = slotKind(k);
      expPix = '0;
      if (kind == KIND_PIXEL) begin
        if (model.size() > 0) expPix = model.pop_front();
        else                  expUnder = 1'b1;
      end
      checks++;
      if (obsFrame !== (kind == KIND_FRAME) || obsLine !== (kind == KIND_LINE) ||
          obsBusy !== (k < fl) || obsPix !== expPix) begin
        errors++;
        $display("FAIL %s k=%0d: got frame=%b line=%b busy=%b pix=%0d, want frame=%b line=%b busy=%b pix=%0d",
                 name, k, obsFrame, obsLine, obsBusy, obsPix,
                 kind == KIND_FRAME, kind == KIND_LINE, k < fl, expPix);
      end
      if (k < fl) step();
    end
    checks++;
    if (obsUnder !== expUnder) begin
      errors++;
      $display("FAIL %s underrun: got %b want %b", name, obsUnder, expUnder);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    selectDut(1'b0);
    doReset();
    checks++;
    if ({obsPix, obsFrame, obsLine, obsBusy, obsUnder, obsReady} !== {8'd0, 4'b0000, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: got pix=%0d f=%b l=%b b=%b u=%b rdy=%b want 0 0 0 0 0 1",
               obsPix, obsFrame, obsLine, obsBusy, obsUnder, obsReady);
    end
  endtask

  task automatic test_basic_frame();
    selectDut(1'b0);
    doReset();
    pushPixels(8, 1'b1);
    enable = 1'b1;
    runFrame("basic_frame");
  endtask

  task automatic test_underrun();
    selectDut(1'b0);
    doReset();
    pushPixels(6, 1'b0);
    enable = 1'b1;
    runFrame("underrun_frame");
    repeat (5) step();
    checks++;
    if (obsUnder !== 1'b1) begin
      errors++;
      $display("FAIL underrun_sticky: got %b want 1", obsUnder);
    end
    doReset();
    checks++;
    if (obsUnder !== 1'b0) begin
      errors++;
      $display("FAIL underrun_clear: got %b want 0", obsUnder);
    end
  endtask

  task automatic test_fifo_full();
    bit strobe;
    selectDut(1'b0);
    doReset();
    pushPixels(DEPTH + 1, 1'b0);
    checks++;
    if (obsReady !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: got %b want 0", obsReady);
    end
    strobe = 1'b0;
    repeat (6) begin
      step();
      if (obsFrame !== 1'b0 || obsLine !== 1'b0 || obsBusy !== 1'b0) strobe = 1'b1;
    end
    checks++;
    if (strobe) begin
      errors++;
      $display("FAIL full_no_strobe: got strobe/busy while disabled, want none");
    end
    enable = 1'b1;
    runFrame("full_frame_a");
    enable = 1'b1;
    runFrame("full_frame_b");
  endtask

  task automatic test_back_to_back();
    int         fl, k, nFrames, lastF, kind;
    bit         inFrame, acc;
    logic [7:0] d, expPix;
    selectDut(1'b0);
    doReset();
    fl      = frameLen();
    nFrames = 0;
    lastF   = 0;
    k       = 0;
    inFrame = 1'b0;
    enable  = 1'b1;
    inValid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      inData = 8'($urandom);
      d      = inData;
      acc    = (obsReady === 1'b1);
      step();
      if (acc) model.push_back(d);
      if (obsFrame === 1'b1) begin
        if (nFrames > 0) begin
          checks++;
          if (cyc - lastF != fl + 1) begin
            errors++;
            $display("FAIL b2b_interval: got %0d want %0d", cyc - lastF, fl + 1);
          end
        end
        lastF   = cyc;
        nFrames++;
        k       = 0;
        inFrame = 1'b1;
      end else if (inFrame) begin
        k++;
      end
      if (inFrame && k < fl && k > 0) begin
        kind   = slotKind(k);
        expPix = '0;
        if (kind == KIND_PIXEL && model.size() > 0) expPix = model.pop_front();
        checks++;
        if (obsLine !== (kind == KIND_LINE) || obsPix !== expPix) begin
          errors++;
          $display("FAIL b2b_slot k=%0d: got line=%b pix=%0d want line=%b pix=%0d",
                   k, obsLine, obsPix, kind == KIND_LINE, expPix);
        end
      end
      if (nFrames == 3 && k >= fl - 1) break;
    end
    checks++;
    if (nFrames < 3 || obsUnder !== 1'b0) begin
      errors++;
      $display("FAIL b2b_frames: got frames=%0d underrun=%b want 3 and 0", nFrames, obsUnder);
    end
    inValid = 1'b0;
    enable  = 1'b0;
    doReset();
  endtask

  task automatic test_reset_mid_frame();
    bit         found, strobe;
    logic [7:0] expPix;
    selectDut(1'b0);
    doReset();
    pushPixels(8, 1'b0);
    enable = 1'b1;
    waitFrame("mid_reset", found);
    if (!found) return;
    enable = 1'b0;
    repeat (9) step();
    expPix = model[4];
    checks++;
    if (obsPix !== expPix) begin
      errors++;
      $display("FAIL mid_reset_line2_pix: got %0d want %0d", obsPix, expPix);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    model.delete();
    expUnder = 1'b0;
    checks++;
    if ({obsPix, obsFrame, obsLine, obsBusy, obsUnder, obsReady} !== {8'd0, 4'b0000, 1'b1}) begin
      errors++;
      $display("FAIL mid_reset_state: got pix=%0d f=%b l=%b b=%b u=%b rdy=%b want 0 0 0 0 0 1",
               obsPix, obsFrame, obsLine, obsBusy, obsUnder, obsReady);
    end
    strobe = 1'b0;
    repeat (25) begin
      step();
      if (obsFrame !== 1'b0 || obsLine !== 1'b0 || obsBusy !== 1'b0) strobe = 1'b1;
    end
    checks++;
    if (strobe) begin
      errors++;
      $display("FAIL mid_reset_quiet: got strobe/busy after reset, want none");
    end
  endtask

  task automatic test_no_blank();
    selectDut(1'b1);
    doReset();
    pushPixels(8, 1'b0);
    enable = 1'b1;
    runFrame("no_blank_frame");
    selectDut(1'b0);
  endtask

  initial begin
    selectDut(1'b0);
    reset    = 1'b0;
    enable   = 1'b0;
    inValid  = 1'b0;
    inData   = '0;
    expUnder = 1'b0;
    test_reset();
    test_basic_frame();
    test_underrun();
    test_fifo_full();
    test_back_to_back();
    test_reset_mid_frame();
    test_no_blank();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/video_framer.md
# video_framer

Stream transmitter for the pixel pipeline. Accepts raw 8-bit pixels over a valid/ready handshake, buffers them in a small FIFO, and emits them as the Pixel/Frame/Line raster stream consumed by the edge/resize/circle chain, inserting the Frame and Line strobes and horizontal/vertical blanking. Used as the bench-side and on-chip source that feeds the Hough pipeline input.

## Interface
- WIDTH, 64, active pixels per line (≥1)
- HEIGHT, 48, lines per frame (≥1)
- HBLANK, 4, idle cycles after each line's last pixel (≥0)
- VBLANK, 8, idle cycles after a frame's last line (≥0)
- FIFO_DEPTH, 16, input buffer entries (power of 2, ≥2)

- Clk  in  1  clock; all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- Enable  in  1  allows a new frame to start; sampled only in IDLE
- InData  in  8  pixel to buffer
- InValid  in  1  InData valid
- InReady  out  1  FIFO can accept; transfer when InValid&&InReady
- PixelOut  out  8  raster pixel; 0 outside active region
- FrameOut  out  1  one-cycle frame-start strobe
- LineOut  out  1  one-cycle line-start strobe
- Busy  out  1  high from FRAME until VBLK completes
- Underrun  out  1  sticky: an active cycle found the FIFO empty

## Operation
- FSM states: IDLE, FRAME, LINE, ACTIVE, HBLK, VBLK.
- IDLE: leave to FRAME when Enable=1 and FIFO non-empty; else stay.
- FRAME: 1 cycle -> LINE; line counter cleared.
- LINE: 1 cycle -> ACTIVE; pixel counter cleared.
- ACTIVE: WIDTH cycles, one FIFO pop per cycle if non-empty. Then -> HBLK if HBLANK>0, else directly to LINE/VBLK per the next rule.
- HBLK: HBLANK cycles, then line counter +1; if lines emitted == HEIGHT -> VBLK (or IDLE if VBLANK=0), else LINE.
- VBLK: VBLANK cycles -> IDLE. Back-to-back frames therefore have exactly one IDLE cycle between VBLK end and next FRAME.
- Frame length from FRAME entry to IDLE entry: 1 + HEIGHT*(1+WIDTH+HBLANK) + VBLANK cycles.
- Underrun: ACTIVE cycle with FIFO empty -> PixelOut=0 for that slot, Underrun set; raster timing never stalls. Cleared only by Reset.
- Enable dropping mid-frame: current frame completes; no new FRAME.
- FIFO: InReady = !full. Simultaneous push and pop allowed at any level, including full (push refused since InReady=0) and empty (pop skipped, push lands).
- Counters sized $clog2(max+1); no wrap within legal parameter ranges.

## Timing
- Outputs registered: PixelOut/FrameOut/LineOut/Busy reflect the FSM state of the previous cycle (1-cycle latency).
- FrameOut high exactly one cycle; LineOut high the following cycle; first pixel on PixelOut the cycle after LineOut.
- A pixel pushed in cycle n is eligible for pop in cycle n+1 (no same-cycle bypass).
- Reset: next cycle PixelOut=0, FrameOut=0, LineOut=0, Busy=0, Underrun=0, InReady=1, FIFO empty, FSM=IDLE. Applies mid-frame with no partial strobes afterward.
- Pixel order out equals acceptance order in.

## Structure
- Shared package: FSM state enum, pixel width constant (8).
- One sub-module: pixel_fifo (synchronous FIFO, FIFO_DEPTH×8, full/empty, push/pop).
- FSM, counters, output registers in video_framer.

## Test plan
- WIDTH=4, HEIGHT=2, HBLANK=2, VBLANK=3; preload 8 pixels 1..8, Enable=1 -> FrameOut at cycle t, LineOut t+1, pixels 1,2,3,4 at t+2..t+5, LineOut t+8, pixels 5..8 at t+9..t+12, Busy falls after 18 state cycles; Underrun=0.
- Same config, only 6 pixels supplied -> last line outputs 5,6,0,0; Underrun=1 and stays 1 until Reset.
- Fill FIFO to 16 with Enable=0 -> InReady=0, no strobes; push attempted while full is dropped; Enable=1 -> all 16 emerge in order.
- Enable held high, continuous supply -> consecutive FrameOut pulses exactly 19 cycles apart (18+1 IDLE).
- Reset asserted during ACTIVE of line 2 -> next cycle all outputs 0, InReady=1; no further LineOut until a new frame starts.
- HBLANK=0, VBLANK=0 -> LineOut immediately follows last pixel of previous line; frame length 1+HEIGHT*(1+WIDTH).
